// File: rtl/dma_ctrl.sv
// Memory-to-memory DMA engine for the 65C02 bus: stalls the CPU through rdy,
// copies LEN bytes from SRC to DST in bursts, then raises done/irq.
module dma_ctrl #(
  parameter int BURST      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        rdy,
  output logic        irq,
  output logic        dma_act,
  output logic [15:0] dma_ab,
  output logic        dma_we,
  output logic [7:0]  dma_do,
  input  logic [7:0]  dma_di
);

  typedef enum logic [2:0] {IDLE, RD, WR, REL, GAP} state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] src, dst, len;
  logic        ien, src_fix, dst_fix, done;
  logic [7:0]  bcnt;
  logic [3:0]  gcnt;
  logic [7:0]  rdata;
  logic        busy, ctrl_wr, stat_wr, reg_wr, start_ok, abort_wr, done_set;

  assign busy     = (state != IDLE);
  assign ctrl_wr  = cs & we & (addr == 3'd6);
  assign stat_wr  = cs & we & (addr == 3'd7);
  assign reg_wr   = cs & we & ~busy;
  // Abort has priority over start when both bits arrive in one write.
  assign start_ok = ctrl_wr & din[0] & ~din[4];
  assign abort_wr = ctrl_wr & din[4];
  assign done_set = ((state == REL) && (len == 16'd0)) ||
                    ((state == IDLE) && start_ok && (len == 16'd0));
  assign irq      = done & ien;

  always_comb begin
    state_nxt = state;
    rdy       = 1'b1;
    dma_act   = 1'b0;
    dma_we    = 1'b0;
    dma_ab    = 16'h0000;
    dma_do    = 8'h00;
    case (state)
      IDLE: if (start_ok && (len != 16'd0)) state_nxt = RD;
      RD: begin
        rdy       = 1'b0;
        dma_act   = 1'b1;
        dma_ab    = src;
        state_nxt = WR;
      end
      WR: begin
        rdy     = 1'b0;
        dma_act = 1'b1;
        dma_ab  = dst;
        dma_we  = 1'b1;
        dma_do  = dma_di;
        if ((len == 16'd1) || (bcnt == BURST_LAST)) state_nxt = REL;
        else                                        state_nxt = RD;
      end
      // One stalled cycle with the bus released so memory re-reads CPU_AB.
      REL: begin
        rdy       = 1'b0;
        state_nxt = (len == 16'd0) ? IDLE : GAP;
      end
      GAP: begin
        if (abort_wr)              state_nxt = IDLE;
        else if (gcnt == GAP_LAST) state_nxt = RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      3'd0: rdata = src[7:0];
      3'd1: rdata = src[15:8];
      3'd2: rdata = dst[7:0];
      3'd3: rdata = dst[15:8];
      3'd4: rdata = len[7:0];
      3'd5: rdata = len[15:8];
      3'd6: rdata = {4'b0000, dst_fix, src_fix, ien, 1'b0};
      3'd7: rdata = {done, 6'b000000, busy};
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src     <= 16'h0000;
      dst     <= 16'h0000;
      len     <= 16'h0000;
      ien     <= 1'b0;
      src_fix <= 1'b0;
      dst_fix <= 1'b0;
      done    <= 1'b0;
      bcnt    <= 8'h00;
      gcnt    <= 4'h0;
      dout    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (reg_wr) begin
        case (addr)
          3'd0: src[7:0]  <= din;
          3'd1: src[15:8] <= din;
          3'd2: dst[7:0]  <= din;
          3'd3: dst[15:8] <= din;
          3'd4: len[7:0]  <= din;
          3'd5: len[15:8] <= din;
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        ien     <= din[1];
        src_fix <= din[2];
        dst_fix <= din[3];
      end
      if (state == WR) begin
        src <= src + {15'd0, ~src_fix};
        dst <= dst + {15'd0, ~dst_fix};
        len <= len - 16'd1;
      end
      if (state == WR)      bcnt <= bcnt + 8'd1;
      else if (state != RD) bcnt <= 8'h00;
      gcnt <= (state == GAP) ? gcnt + 4'd1 : 4'h0;
      if (done_set)     done <= 1'b1;
      else if (stat_wr) done <= 1'b0;
      if (cs && !we) dout <= rdata;
    end
  end

endmodule
